// File: rtl/pcpu_mem_pkg.sv
// Shared encodings for the pipelined CPU memory responder:
// host opcodes, RAM select values and the host-port FSM states.
package pcpu_mem_pkg;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RRESP = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/pcpu_ram_1w1r.sv
// Register-file RAM with asynchronous CPU and host read ports.
// The primary write lands after the auxiliary one, so it wins on equal addresses.
module pcpu_ram_1w1r #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_aux_we,
  input  logic [AW-1:0] i_aux_waddr,
  input  logic [DW-1:0] i_aux_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  input  logic [AW-1:0] i_haddr,
  output logic [DW-1:0] o_hdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_aux_we) r_mem[i_aux_waddr] <= i_aux_wdata;
    if (i_we)     r_mem[i_waddr]     <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_hdata = r_mem[i_haddr];

endmodule

// File: rtl/pcpu_mem_responder.sv
// Instruction/data RAM pair for the pipelined CPU plus a host port for
// loading, readback and bulk clear while the CPU is idle.
module pcpu_mem_responder
  import pcpu_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_run,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dataout,
  output logic [DW-1:0] d_datain,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic [1:0]    h_op,
  input  logic          h_sel,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_rvalid,
  input  logic          h_rready,
  output logic [DW-1:0] h_rdata,
  output logic          busy
);

  localparam logic [AW:0] C_LAST = {1'b0, {AW{1'b1}}};

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic          r_sel;

  logic          w_accept;
  logic          w_host_wr;
  logic          w_clr_wr;
  logic [AW-1:0] w_haux_addr;
  logic [DW-1:0] w_haux_data;
  logic          w_imem_we;
  logic          w_dmem_aux_we;
  logic [DW-1:0] w_imem_h;
  logic [DW-1:0] w_dmem_h;

  assign h_ready = (r_state == ST_IDLE) && !cpu_run;

  // Reset gates the host and clear writes so an aborted clear stops cleanly.
  assign w_accept    = h_valid && h_ready && !rst;
  assign w_host_wr   = w_accept && (h_op == OP_WR);
  assign w_clr_wr    = (r_state == ST_CLEAR) && !cpu_run && !rst;
  assign w_haux_addr = w_clr_wr ? r_cnt[AW-1:0] : h_addr;
  assign w_haux_data = w_clr_wr ? '0 : h_wdata;

  assign w_imem_we     = (w_host_wr && (h_sel == SEL_IMEM)) || (w_clr_wr && (r_sel == SEL_IMEM));
  assign w_dmem_aux_we = (w_host_wr && (h_sel == SEL_DMEM)) || (w_clr_wr && (r_sel == SEL_DMEM));

  pcpu_ram_1w1r #(.AW(AW), .DW(DW)) u_imem (
    .clk         (clk),
    .i_we        (w_imem_we),
    .i_waddr     (w_haux_addr),
    .i_wdata     (w_haux_data),
    .i_aux_we    (1'b0),
    .i_aux_waddr ('0),
    .i_aux_wdata ('0),
    .i_raddr     (i_addr),
    .o_rdata     (i_datain),
    .i_haddr     (h_addr),
    .o_hdata     (w_imem_h)
  );

  // The CPU owns the primary dmem port so its store wins an address collision.
  pcpu_ram_1w1r #(.AW(AW), .DW(DW)) u_dmem (
    .clk         (clk),
    .i_we        (d_we),
    .i_waddr     (d_addr),
    .i_wdata     (d_dataout),
    .i_aux_we    (w_dmem_aux_we),
    .i_aux_waddr (w_haux_addr),
    .i_aux_wdata (w_haux_data),
    .i_raddr     (d_addr),
    .o_rdata     (d_datain),
    .i_haddr     (h_addr),
    .o_hdata     (w_dmem_h)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= SEL_IMEM;
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (h_op)
              OP_RD: begin
                h_rdata  <= (h_sel == SEL_DMEM) ? w_dmem_h : w_imem_h;
                h_rvalid <= 1'b1;
                r_state  <= ST_RRESP;
              end
              OP_CLR: begin
                r_cnt   <= '0;
                r_sel   <= h_sel;
                busy    <= 1'b1;
                r_state <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
        ST_RRESP: begin
          if (h_rready) begin
            h_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (!cpu_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
